// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the Y86-64 execute stage: ALU/condition codes,
// CC bit positions and the jXX/cmovXX condition evaluator.
package alu_exec_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fun_e;

  typedef enum logic [2:0] {
    C_YES = 3'd0,
    C_LE  = 3'd1,
    C_L   = 3'd2,
    C_E   = 3'd3,
    C_NE  = 3'd4,
    C_GE  = 3'd5,
    C_G   = 3'd6
  } cond_fun_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  // Returns {illegal, cnd}; an illegal code always yields cnd=0.
  function automatic logic [1:0] cond_eval(input logic [2:0] cf, input logic [2:0] cc);
    logic zf, lt;
    zf = cc[CC_ZF];
    lt = cc[CC_SF] ^ cc[CC_OF];
    case (cf)
      C_YES:   cond_eval = 2'b01;
      C_LE:    cond_eval = {1'b0, lt | zf};
      C_L:     cond_eval = {1'b0, lt};
      C_E:     cond_eval = {1'b0, zf};
      C_NE:    cond_eval = {1'b0, !zf};
      C_GE:    cond_eval = {1'b0, !lt};
      C_G:     cond_eval = {1'b0, !lt && !zf};
      default: cond_eval = 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational Y86 ALU: ADD (a+b), SUB (b-a), AND, XOR plus the flag values
// the CC register would take from this result.
module alu_exec_unit_core
  import alu_exec_unit_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         illegal
);

  always_comb begin
    result  = '0;
    of      = 1'b0;
    illegal = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = a + b;
        of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
      end
      // Y86 subtracts A from B, so the overflow test is anchored on b's sign.
      ALU_SUB: begin
        result = b - a;
        of     = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: illegal = 1'b1;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[W-1];

endmodule

// File: rtl/alu_exec_unit.sv
// Registered Y86-64 execute stage: one result register behind a valid/ready
// pair, plus the ZF/SF/OF condition-code register and cnd evaluation.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_fun,
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  logic         set_cc,
  input  logic [2:0]   cond_fun,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] val_e,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         err
);

  // Handshake: a beat moves on a channel in any cycle where valid && ready
  // at the rising edge. Upstream accept happens when the result register is
  // empty or is being drained in the same cycle; held outputs never change.

  logic [W-1:0] val_e_q, val_e_d;
  logic         cnd_q, cnd_d;
  logic         err_q, err_d;
  logic         out_valid_q, out_valid_d;
  logic [2:0]   cc_q, cc_d;

  logic [W-1:0] core_result;
  logic         core_zf, core_sf, core_of, core_illegal;
  logic [1:0]   cond_res;
  logic         accept;

  alu_exec_unit_core #(.W(W)) u_core (
    .fun     (alu_fun),
    .a       (alu_a),
    .b       (alu_b),
    .result  (core_result),
    .zf      (core_zf),
    .sf      (core_sf),
    .of      (core_of),
    .illegal (core_illegal)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // cnd looks at the CC register as it stands before this beat's update.
  assign cond_res = cond_eval(cond_fun, cc_q);

  always_comb begin
    val_e_d     = val_e_q;
    cnd_d       = cnd_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    cc_d        = cc_q;
    if (accept) begin
      val_e_d     = core_result;
      cnd_d       = cond_res[0];
      err_d       = core_illegal || cond_res[1];
      out_valid_d = 1'b1;
      if (set_cc && !core_illegal) begin
        cc_d[CC_ZF] = core_zf;
        cc_d[CC_SF] = core_sf;
        cc_d[CC_OF] = core_of;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_e_q     <= '0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      val_e_q     <= val_e_d;
      cnd_q       <= cnd_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      cc_q        <= cc_d;
    end
  end

  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus a randomized run against
// an arithmetic reference model with an expected-result queue.
module tb_alu_exec_unit;

  localparam int W = 64;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_fun;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         set_cc;
  logic [2:0]   cond_fun;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] val_e;
  logic         cnd;
  logic [2:0]   cc;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [W-1:0] exp_q[$];
  logic         cnd_q[$];
  logic         err_q[$];
  logic         m_valid;
  logic [2:0]   m_cc;
  logic         last_acc;
  logic         obs_in_ready;

  alu_exec_unit #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_fun   (alu_fun),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .set_cc    (set_cc),
    .cond_fun  (cond_fun),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e     (val_e),
    .cnd       (cnd),
    .cc        (cc),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    cnd_q.delete();
    err_q.delete();
    m_valid = 1'b0;
    m_cc    = 3'b100;
  endtask

  // Reference: signed arithmetic at full precision; overflow means the true
  // sum/difference does not fit in W signed bits.
  task automatic ref_beat(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sc, input logic [2:0] cf);
    logic signed [W+1:0] sa, sb, s, lim_hi, lim_lo;
    logic [W-1:0] r;
    logic ovf, legal, c, cerr, z, n;
    sa = $signed({{2{a[W-1]}}, a});
    sb = $signed({{2{b[W-1]}}, b});
    lim_hi = $signed({3'b000, {(W-1){1'b1}}});
    lim_lo = $signed({3'b111, {(W-1){1'b0}}});
    ovf = 1'b0; legal = 1'b1; r = '0;
    case (f)
      4'd0: begin s = sa + sb; r = s[W-1:0]; ovf = (s > lim_hi) || (s < lim_lo); end
      4'd1: begin s = sb - sa; r = s[W-1:0]; ovf = (s > lim_hi) || (s < lim_lo); end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      default: legal = 1'b0;
    endcase
    z = m_cc[2];
    n = m_cc[1] ^ m_cc[0];  // signed "less than" after a compare
    cerr = 1'b0;
    case (cf)
      3'd0: c = 1'b1;
      3'd1: c = n || z;
      3'd2: c = n;
      3'd3: c = z;
      3'd4: c = !z;
      3'd5: c = !n;
      3'd6: c = !n && !z;
      default: begin c = 1'b0; cerr = 1'b1; end
    endcase
    exp_q.push_back(r);
    cnd_q.push_back(c);
    err_q.push_back(!legal || cerr);
    if (sc && legal) m_cc = {(r == '0), r[W-1], ovf};
  endtask

  // driver: apply one cycle of inputs, advance model, step to next negedge
  task automatic drive(input logic iv, input logic [3:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sc, input logic [2:0] cf,
                       input logic ordy);
    in_valid = iv; alu_fun = f; alu_a = a; alu_b = b;
    set_cc = sc; cond_fun = cf; out_ready = ordy;
    #1;
    obs_in_ready = in_ready;
    last_acc = iv && (!m_valid || ordy);
    if (m_valid && ordy) begin
      void'(exp_q.pop_front());
      void'(cnd_q.pop_front());
      void'(err_q.pop_front());
      m_valid = 1'b0;
    end
    if (last_acc) begin
      ref_beat(f, a, b, sc, cf);
      m_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 4'd0, '0, '0, 1'b0, 3'd0, ordy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; alu_fun = '0; alu_a = '0; alu_b = '0;
    set_cc = 1'b0; cond_fun = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (val_e !== '0) begin n_fail++; $display("FAIL reset_val_e got %h exp 0", val_e); end
    n_tests++; if ({cnd, err} !== 2'b00) begin n_fail++; $display("FAIL reset_cnd_err got %b exp 00", {cnd, err}); end
    n_tests++; if (cc !== 3'b100) begin n_fail++; $display("FAIL reset_cc got %b exp 100", cc); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add_overflow();
    drive(1'b1, 4'd0, MAX_POS, 64'd1, 1'b1, 3'd0, 1'b1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_ovf_valid got %b exp 1", out_valid); end
    n_tests++; if (val_e !== MIN_NEG) begin n_fail++; $display("FAIL add_ovf_val got %h exp %h", val_e, MIN_NEG); end
    n_tests++; if (cc !== 3'b011) begin n_fail++; $display("FAIL add_ovf_cc got %b exp 011", cc); end
    idle(1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_ovf_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_sub_equal();
    drive(1'b1, 4'd1, 64'd5, 64'd5, 1'b1, 3'd0, 1'b1);
    n_tests++; if (val_e !== '0) begin n_fail++; $display("FAIL sub_eq_val got %h exp 0", val_e); end
    n_tests++; if (cc !== 3'b100) begin n_fail++; $display("FAIL sub_eq_cc got %b exp 100", cc); end
    drive(1'b1, 4'd0, 64'd0, 64'd0, 1'b0, 3'd3, 1'b1);
    n_tests++; if (cnd !== 1'b1) begin n_fail++; $display("FAIL sub_eq_cnd_e got %b exp 1", cnd); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_eq_b2b_valid got %b exp 1", out_valid); end
    // SUB is b-a: 3-10 is negative, 10-3 positive
    drive(1'b1, 4'd1, 64'd10, 64'd3, 1'b1, 3'd0, 1'b1);
    n_tests++; if (val_e !== 64'hFFFF_FFFF_FFFF_FFF9) begin n_fail++; $display("FAIL sub_order_val got %h exp fffffffffffffff9", val_e); end
    n_tests++; if (cc !== 3'b010) begin n_fail++; $display("FAIL sub_order_cc got %b exp 010", cc); end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 4'd3, 64'hF0, 64'hFF, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd0, 64'd7, 64'd7, 1'b1, 3'd0, 1'b0);
      n_tests++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, obs_in_ready); end
      n_tests++; if (val_e !== 64'h0F || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold cyc %0d got %h/%b exp 0f/1", i, val_e, out_valid); end
    end
    drive(1'b1, 4'd0, 64'd1, 64'd2, 1'b0, 3'd0, 1'b1);
    n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", obs_in_ready); end
    n_tests++; if (val_e !== 64'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_val got %h/%b exp 3/1", val_e, out_valid); end
    idle(1'b1);
  endtask

  task automatic test_no_setcc();
    drive(1'b1, 4'd0, MAX_POS, 64'd1, 1'b1, 3'd0, 1'b1);
    drive(1'b1, 4'd0, 64'd1, '1, 1'b0, 3'd0, 1'b1);
    n_tests++; if (val_e !== '0) begin n_fail++; $display("FAIL nocc_val got %h exp 0", val_e); end
    n_tests++; if (cc !== 3'b011) begin n_fail++; $display("FAIL nocc_cc got %b exp 011", cc); end
    drive(1'b1, 4'd2, 64'hFF, 64'h0F, 1'b0, 3'd6, 1'b1);
    n_tests++; if (cnd !== cnd_q[0] || val_e !== 64'h0F) begin
      n_fail++; $display("FAIL nocc_cnd_g got %b/%h exp %b/0f", cnd, val_e, cnd_q[0]); end
    idle(1'b1);
  endtask

  task automatic test_illegal();
    logic [2:0] cc_before;
    cc_before = m_cc;
    drive(1'b1, 4'h9, 64'd4, 64'd4, 1'b1, 3'd0, 1'b1);
    n_tests++; if ({val_e, err} !== {64'd0, 1'b1}) begin
      n_fail++; $display("FAIL ill_alu got %h/%b exp 0/1", val_e, err); end
    n_tests++; if (cc !== cc_before) begin n_fail++; $display("FAIL ill_alu_cc got %b exp %b", cc, cc_before); end
    drive(1'b1, 4'd0, 64'd2, 64'd3, 1'b0, 3'd7, 1'b1);
    n_tests++; if ({cnd, err, val_e} !== {1'b0, 1'b1, 64'd5}) begin
      n_fail++; $display("FAIL ill_cond got %b/%b/%h exp 0/1/5", cnd, err, val_e); end
    drive(1'b1, 4'd0, 64'd2, 64'd3, 1'b0, 3'd0, 1'b1);
    n_tests++; if ({cnd, err} !== 2'b10) begin n_fail++; $display("FAIL ill_recover got %b exp 10", {cnd, err}); end
    idle(1'b1);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: rand_operand = '0;
      1: rand_operand = MAX_POS;
      2: rand_operand = MIN_NEG;
      3: rand_operand = '1;
      default: rand_operand = {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic test_random();
    logic [3:0] f;
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, f, rand_operand(), rand_operand(),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      n_tests++; if (out_valid !== m_valid || cc !== m_cc) begin
        n_fail++; $display("FAIL rand_state cyc %0d got %b/%b exp %b/%b", i, out_valid, cc, m_valid, m_cc); end
      if (m_valid) begin
        n_tests++; if (val_e !== exp_q[0] || cnd !== cnd_q[0] || err !== err_q[0]) begin
          n_fail++; $display("FAIL rand_beat cyc %0d got %h/%b/%b exp %h/%b/%b",
                             i, val_e, cnd, err, exp_q[0], cnd_q[0], err_q[0]); end
      end
    end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd0, 64'd1, 64'd1, 1'b1, 3'd0, 1'b1);
    idle(1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0 || cc !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_async got %b/%b exp 0/100", out_valid, cc); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    n_tests++; if (out_valid !== 1'b0 || val_e !== '0) begin
      n_fail++; $display("FAIL rstmid_dropped got %b/%h exp 0/0", out_valid, val_e); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_equal();
    test_backpressure();
    test_no_setcc();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
